// File: rtl/data_serializer.sv
// Parallel-to-serial frame sender: captures STAGE words on load and emits them one per transfer.
// Define DATA_SERIALIZER_BACKPRESSURE_EN to honour out_ready; otherwise a word advances every SHIFT cycle.
module data_serializer #(
    parameter int STAGE  = 8,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] data_d [0:STAGE-1],
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(STAGE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [DWIDTH-1:0] buffer [0:STAGE-1];
    logic [DWIDTH-1:0] hold_q;
    logic              capture;
    logic              ready_eff;

`ifdef DATA_SERIALIZER_BACKPRESSURE_EN
    assign ready_eff = out_ready;
`else
    logic unused_ready;
    assign unused_ready = out_ready;
    assign ready_eff    = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        out_data  = hold_q;
        case (state)
            IDLE: begin
                if (load) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = buffer[idx];
                out_last  = (idx == LAST_IDX);
                if (ready_eff) begin
                    // The final transfer leaves idx parked at the last word instead of wrapping.
                    if (idx == LAST_IDX) state_nxt = DONE;
                    else                 idx_nxt   = idx + IW'(1);
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            hold_q <= '0;
            for (int i = 0; i < STAGE; i++) buffer[i] <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // Remember the word on the bus so out_data keeps it once the frame ends.
            if (state == SHIFT) hold_q <= buffer[idx];
            if (capture) begin
                for (int i = 0; i < STAGE; i++) buffer[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_data_serializer.sv
// Scoreboard bench for data_serializer: a frame-level model queues expected words, a monitor checks every cycle.
module tb_data_serializer;

    localparam int STAGE  = 8;
    localparam int DWIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic [DWIDTH-1:0] data_d [0:STAGE-1];
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;

    data_serializer #(.STAGE(STAGE), .DWIDTH(DWIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_d    (data_d),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: words still owed in the current frame plus a one-cycle done marker.
    logic [DWIDTH-1:0] exp_q [$];
    int                words_left = 0;
    bit                in_done    = 1'b0;
    logic [DWIDTH-1:0] last_shown = '0;

    function automatic bit ready_eff();
`ifdef DATA_SERIALIZER_BACKPRESSURE_EN
        return out_ready;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            words_left = 0;
            in_done    = 1'b0;
            exp_q.delete();
            last_shown = '0;
        end else if (words_left > 0) begin
            if (ready_eff()) begin
                words_left--;
                if (words_left == 0) in_done = 1'b1;
            end
        end else if (in_done) begin
            in_done = 1'b0;
        end else if (load) begin
            exp_q.delete();
            for (int i = 0; i < STAGE; i++) exp_q.push_back(data_d[i]);
            words_left = STAGE;
        end
    end

    initial forever begin
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(words_left > 0));
        check("busy",      32'(busy),      32'(words_left > 0));
        check("done",      32'(done),      32'(in_done));
        check("out_last",  32'(out_last),  32'(words_left == 1));
        if (words_left > 0) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
                last_shown = exp_q[0];
                if (ready_eff() && !rst) void'(exp_q.pop_front());
            end
        end else begin
            check("out_data_idle", 32'(out_data), 32'(last_shown));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_frame(input logic [DWIDTH-1:0] base);
        for (int i = 0; i < STAGE; i++) data_d[i] = base + DWIDTH'(i);
    endtask

    task automatic set_random_frame();
        for (int i = 0; i < STAGE; i++) data_d[i] = DWIDTH'($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        out_ready = 1'b1;
        set_frame(8'h00);
        tick(3);
        rst = 1'b0;
        tick(2);

        // Basic frame 0x10..0x17
        set_frame(8'h10);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(12);

        // Second load with 0xAA.. while shifting must not disturb the frame
        set_frame(8'h10);
        load = 1'b1;
        tick(1);
        for (int i = 0; i < STAGE; i++) data_d[i] = 8'hAA;
        tick(3);
        load = 1'b0;
        tick(10);

        // Stall while 0x12 is on the bus
        set_frame(8'h10);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(2);
        out_ready = 1'b0;
        tick(3);
        out_ready = 1'b1;
        tick(12);

        // Reset while 0x14 is on the bus
        set_frame(8'h10);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);

        // Load held high: back-to-back frames with fresh data each cycle
        load = 1'b1;
        for (int i = 0; i < 24; i++) begin
            set_random_frame();
            tick(1);
        end
        load = 1'b0;
        tick(12);

        // out_ready low throughout (ignored unless backpressure is built in)
        out_ready = 1'b0;
        set_frame(8'h40);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(6);
        out_ready = 1'b1;
        tick(14);

        // Random mix of loads, stalls and occasional resets
        for (int i = 0; i < 300; i++) begin
            set_random_frame();
            load      = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 59) == 0);
            tick(1);
        end
        rst       = 1'b0;
        load      = 1'b0;
        out_ready = 1'b1;
        tick(15);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
